pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register and successor of the fixed ID/EX-style stage register.
- Adds a valid/ready handshake, an optional 2-entry skid buffer that breaks the combinational ready path, and configurable flush data clearing.
- Adds saturating stall and bubble performance counters.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the payload is an opaque packed vector.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- SKID, 1, 1 = 2-entry skid buffer with registered ready; 0 = single register with combinational ready (bubble collapse).
- CLEAR_DATA, 1, 1 = payload registers zeroed on reset/flush; 0 = payload holds its value, only valid bits cleared.
- CNT_W, 32, width of each performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_flush  in  1  kill all stage contents this cycle.
- i_stall  in  1  external hold; no transfer in or out this cycle.
- i_valid  in  1  upstream payload valid.
- i_data  in  WIDTH  upstream payload.
- o_ready  out  1  stage can accept this cycle.
- o_valid  out  1  downstream payload valid.
- o_data  out  WIDTH  downstream payload.
- i_ready  in  1  downstream accepts.
- o_occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- o_stall_cnt  out  CNT_W  cycles the head entry was held.
- o_bubble_cnt  out  CNT_W  cycles the stage presented no valid payload.

Behaviour:
- Storage:
  - Head entry M (m_valid, m_data) drives o_valid/o_data directly from flops.
  - Skid entry S (s_valid, s_data) exists only when SKID=1.
- Transfer definitions:
  - fire_in = i_valid && o_ready.
  - fire_out = m_valid && i_ready && !i_stall && !i_flush.
- o_ready:
  - SKID=1: !s_valid && !i_stall && !i_flush. No combinational path from i_ready.
  - SKID=0: (!m_valid || i_ready) && !i_stall && !i_flush.
- Latency: a payload accepted at edge N appears on o_valid/o_data after edge N. Throughput is 1 per cycle with no backpressure.
- Update priority per edge (highest first):
  1. Reset (!i_rst_n): m_valid=s_valid=0, counters=0. Payloads=0 if CLEAR_DATA, else unchanged.
  2. i_flush: m_valid=s_valid=0. Payloads=0 if CLEAR_DATA. Counters keep counting. Flush overrides i_stall. Input offered in the flush cycle is dropped.
  3. i_stall: all entries hold; nothing enters or leaves.
  4. Normal handshake (SKID=1):
     - M empty, or fire_out with S empty: fire_in loads M.
     - fire_out with S valid: S moves to M. S is refilled by fire_in if one occurs (o_ready was 1 only when S was empty, so this cannot happen in the same cycle).
     - M valid, no fire_out, fire_in: payload goes to S; o_ready drops the next cycle.
     - fire_out, no fire_in, S empty: m_valid=0.
  5. Normal handshake (SKID=0): fire_in loads M; fire_out without fire_in clears m_valid; both together replace M.
- Order: payloads leave in acceptance order. No duplication or loss except on flush/reset.
- o_occupancy = m_valid + s_valid.
- o_stall_cnt: +1 on each edge where m_valid && !fire_out && !i_flush && i_rst_n. Saturates at all-ones.
- o_bubble_cnt: +1 on each edge where !m_valid && i_rst_n. Saturates at all-ones.
- Invariant: s_valid implies m_valid.
- Reset mid-transfer: all in-flight payloads are discarded, and o_valid is 0 on the cycle after the reset edge.
- X on i_data is tolerated when i_valid=0. The payload flops may load it, but o_valid stays 0.

Test Plan:
- Streaming: SKID=1, WIDTH=32, i_ready=1, values 0x1..0x8 on consecutive cycles -> o_data shows 0x1..0x8 one cycle later, back-to-back; o_occupancy=1; o_stall_cnt=0.
- Backpressure skid: hold i_ready=0 after 0xA accepted, offer 0xB -> 0xB goes to S; o_ready=0 next cycle; o_occupancy=2. Release i_ready -> 0xA then 0xB delivered in order, o_ready returns to 1. o_stall_cnt counts each held cycle.
- Flush vs stall: M=0x5, S=0x6, assert i_flush and i_stall together -> next cycle o_valid=0, o_occupancy=0, o_data=0 (CLEAR_DATA=1). Offered input 0x7 dropped.
- External stall: i_stall=1 for 3 cycles with i_valid=1, i_ready=1 -> o_ready=0, o_data frozen, o_stall_cnt +3. Resume -> no duplicate or lost payloads.
- SKID=0 bubble collapse: M empty, i_ready=0, i_valid=1 with 0x3C -> accepted (o_ready=1). Next cycle o_ready=0 until i_ready=1; simultaneous in/out replaces M.
- Counters and reset: CNT_W=4, idle for 20 cycles -> o_bubble_cnt saturates at 15. Pulse i_rst_n=0 for one cycle mid-transfer -> counters=0, o_valid=0 after the edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer (registered o_ready), flush with optional payload clearing, and
// saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SKID       = 1,
    parameter int unsigned CLEAR_DATA = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // Head entry (drives the outputs) and skid entry
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic ready_c;
    logic fire_in;
    logic fire_out;
    logic stall_inc;
    logic bubble_inc;

    // Ready: with a skid entry it only depends on local state, never on i_ready
    always_comb begin
        if (SKID != 0) begin
            ready_c = !s_valid_q && !i_stall && !i_flush;
        end else begin
            ready_c = (!m_valid_q || i_ready) && !i_stall && !i_flush;
        end
        fire_in    = i_valid && ready_c;
        fire_out   = m_valid_q && i_ready && !i_stall && !i_flush;
        stall_inc  = m_valid_q && !fire_out && !i_flush;
        bubble_inc = !m_valid_q;
    end

    // Next-state for the storage entries: flush, then stall, then handshake
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (i_flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            if (CLEAR_DATA != 0) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (!i_stall) begin
            if (SKID != 0) begin
                if (fire_out) begin
                    if (s_valid_q) begin
                        // o_ready was low, so no fire_in can coincide here
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end else if (fire_in) begin
                        m_data_d = i_data;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end else if (fire_in) begin
                    if (!m_valid_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = i_data;
                    end else begin
                        s_valid_d = 1'b1;
                        s_data_d  = i_data;
                    end
                end
            end else begin
                if (fire_in) begin
                    m_valid_d = 1'b1;
                    m_data_d  = i_data;
                end else if (fire_out) begin
                    m_valid_d = 1'b0;
                end
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_valid_q    <= 1'b0;
            s_valid_q    <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            if (CLEAR_DATA != 0) begin
                m_data_q <= '0;
                s_data_q <= '0;
            end
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_ready      = ready_c;
    assign o_valid      = m_valid_q;
    assign o_data       = m_data_q;
    assign o_occupancy  = 2'(m_valid_q) + 2'(s_valid_q);
    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a bubble-collapse instance
// driven by the same inputs, each against a capacity-limited FIFO model.
module tb_pipe_stage_reg;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         stall = 1'b0;
    logic         valid = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data = '0;

    logic         a_ready, a_valid;
    logic [W-1:0] a_data;
    logic [1:0]   a_occ;
    logic [31:0]  a_stall, a_bub;

    logic         b_ready, b_valid;
    logic [W-1:0] b_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_stall, b_bub;

    int checks = 0;
    int errors = 0;

    // Model A: 2-entry FIFO, counters 32 bit
    int          a_cnt = 0;
    logic [31:0] a_ent [2];
    logic [31:0] a_st = 0, a_bu = 0, a_head = 0;
    // Model B: 1-entry stage, counters 4 bit
    int          b_cnt = 0;
    logic [31:0] b_ent = 0, b_st = 0, b_bu = 0;

    logic [31:0] sb_a [$];
    logic [31:0] sb_b [$];

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CLEAR_DATA(1), .CNT_W(32)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
        .i_valid(valid), .i_data(data), .o_ready(a_ready), .o_valid(a_valid),
        .o_data(a_data), .i_ready(ready), .o_occupancy(a_occ),
        .o_stall_cnt(a_stall), .o_bubble_cnt(a_bub)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CLEAR_DATA(0), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
        .i_valid(valid), .i_data(data), .o_ready(b_ready), .o_valid(b_valid),
        .o_data(b_data), .i_ready(ready), .o_occupancy(b_occ),
        .o_stall_cnt(b_stall), .o_bubble_cnt(b_bub)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitors: every payload leaving a stage must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && a_valid && ready && !stall && !flush) begin
            if (sb_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_out unexpected payload actual=%0h expected=none", a_data);
            end else begin
                chk("a_out", a_data, sb_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid && ready && !stall && !flush) begin
            if (sb_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_out unexpected payload actual=%0h expected=none", b_data);
            end else begin
                chk("b_out", b_data, sb_b.pop_front());
            end
        end
    end

    // One clock: drive inputs, compare state outputs with the model, advance model
    task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                       input logic st, input logic fl, input logic rs);
        logic a_rdy, a_fin, a_fout, b_rdy, b_fin, b_fout;
        valid = v; data = d; ready = r; stall = st; flush = fl; rst_n = rs;
        @(negedge clk);
        a_rdy  = (a_cnt < 2) && !st && !fl;
        a_fin  = v && a_rdy;
        a_fout = (a_cnt > 0) && r && !st && !fl;
        b_rdy  = ((b_cnt == 0) || r) && !st && !fl;
        b_fin  = v && b_rdy;
        b_fout = (b_cnt > 0) && r && !st && !fl;

        chk("a_ready", 32'(a_ready), 32'(a_rdy));
        chk("a_valid", 32'(a_valid), 32'(a_cnt > 0));
        chk("a_occ",   32'(a_occ),   32'(a_cnt));
        chk("a_stall", a_stall, a_st);
        chk("a_bub",   a_bub,   a_bu);
        chk("a_data",  a_data,  a_head);
        chk("b_ready", 32'(b_ready), 32'(b_rdy));
        chk("b_valid", 32'(b_valid), 32'(b_cnt > 0));
        chk("b_occ",   32'(b_occ),   32'(b_cnt));
        chk("b_stall", 32'(b_stall), b_st);
        chk("b_bub",   32'(b_bub),   b_bu);
        if (b_cnt > 0) chk("b_data", b_data, b_ent);

        if (!rs) begin
            a_cnt = 0; a_st = 0; a_bu = 0; a_head = 0; sb_a.delete();
            b_cnt = 0; b_st = 0; b_bu = 0; sb_b.delete();
        end else begin
            if ((a_cnt > 0) && !a_fout && !fl && (a_st != 32'hFFFF_FFFF)) a_st = a_st + 1;
            if ((a_cnt == 0) && (a_bu != 32'hFFFF_FFFF)) a_bu = a_bu + 1;
            if ((b_cnt > 0) && !b_fout && !fl && (b_st != 32'd15)) b_st = b_st + 1;
            if ((b_cnt == 0) && (b_bu != 32'd15)) b_bu = b_bu + 1;
            if (fl) begin
                a_cnt = 0; a_head = 0; sb_a.delete();
                b_cnt = 0; sb_b.delete();
            end else begin
                if (a_fout) begin a_ent[0] = a_ent[1]; a_cnt--; end
                if (a_fin) begin a_ent[a_cnt] = d; a_cnt++; sb_a.push_back(d); end
                if (a_cnt > 0) a_head = a_ent[0];
                if (b_fout) b_cnt = 0;
                if (b_fin) begin b_ent = d; b_cnt = 1; sb_b.push_back(d); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_ent[0] = 0;
        a_ent[1] = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then streaming 0x1..0x8 with downstream always ready
        cyc(0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(1, 32'(i), 1, 0, 0, 1);
        repeat (2) cyc(0, 0, 1, 0, 0, 1);

        // Backpressure into the skid entry, then release
        cyc(1, 32'hA, 0, 0, 0, 1);
        cyc(1, 32'hB, 0, 0, 0, 1);
        cyc(1, 32'hC, 0, 0, 0, 1);
        chk("skid_occ", 32'(a_occ), 32'd2);
        repeat (3) cyc(0, 0, 1, 0, 0, 1);

        // Flush together with stall wipes both entries and drops the offer
        cyc(1, 32'h5, 0, 0, 0, 1);
        cyc(1, 32'h6, 0, 0, 0, 1);
        cyc(1, 32'h7, 0, 1, 1, 1);
        chk("flush_valid", 32'(a_valid), 32'd0);
        chk("flush_occ",   32'(a_occ),   32'd0);
        chk("flush_data",  a_data,       32'd0);
        cyc(0, 0, 1, 0, 0, 1);

        // External stall for three cycles mid-stream
        cyc(1, 32'h11, 1, 0, 0, 1);
        repeat (3) cyc(1, 32'h12, 1, 1, 0, 1);
        cyc(1, 32'h13, 1, 0, 0, 1);
        repeat (2) cyc(0, 0, 1, 0, 0, 1);

        // Bubble collapse on the single-register instance
        cyc(1, 32'h3C, 0, 0, 0, 1);
        chk("collapse_valid", 32'(b_valid), 32'd1);
        chk("collapse_data",  b_data,       32'h3C);
        cyc(1, 32'h3D, 0, 0, 0, 1);
        cyc(1, 32'h3E, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 1, 0, 0, 1);

        // Idle long enough for the 4-bit bubble counter to saturate
        repeat (20) cyc(0, 0, 1, 0, 0, 1);
        chk("bub_sat", 32'(b_bub), 32'd15);

        // Randomised traffic with occasional stall, flush and reset
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 3,
                !($urandom_range(0, 99) < 1));
        end

        // Reset pulse mid-transfer
        cyc(1, 32'h21, 0, 0, 0, 1);
        cyc(1, 32'h22, 0, 0, 0, 1);
        cyc(1, 32'h23, 1, 0, 0, 0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_stall", a_stall, 32'd0);
        chk("rst_a_bub",   a_bub,   32'd0);
        repeat (3) cyc(0, 0, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
